data_memory_responder: RTL and testbench

//  Multi-cycle data-memory slave servicing load/store requests from the pipeline MEM stage.

---
 rtl/data_memory_responder_pkg.sv | 20 ++
 rtl/data_memory_responder_dmem_array.sv | 24 ++
 rtl/data_memory_responder.sv | 88 ++++++++
 tb/tb_data_memory_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared encodings, defaults and FSM state type for the data-memory responder
package data_memory_responder_pkg;
  localparam int MEM_OP_BITS = 2;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;
  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_ADDR_WIDTH   = 16;
  localparam int DEFAULT_DEPTH_LOG2   = 10;
  localparam int DMEM_LATENCY_DEFAULT = 2;
  localparam int DMEM_CNT_BITS        = 4;
  typedef enum logic [1:0] {
    DMEM_STATE_IDLE = 2'd0,
    DMEM_STATE_WAIT = 2'd1,
    DMEM_STATE_RESP = 2'd2
  } dmem_state_t;
  function automatic logic is_mem_access(input logic [MEM_OP_BITS-1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction
endpackage

// File: rtl/data_memory_responder_dmem_array.sv
// dmem_array: single-port synchronous storage; write and read both happen on the enable edge.
// Storage has no reset so contents survive it; only the read register clears.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic                  clr,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;
  // rdata doubles as the response data register: zero for write acks and faults
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else if (clr) rdata <= '0;
    else if (en) rdata <= we ? '0 : mem[addr];
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle load/store responder, one transaction in flight, fixed LATENCY.
// Optional DMEM_BOUNDS_CHECK_EN faults out-of-range addresses instead of aliasing them.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LATENCY    = DMEM_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [MEM_OP_BITS-1:0] req_mem_op,
  input  logic [ADDR_WIDTH-1:0]  req_address,
  input  logic [DATA_WIDTH-1:0]  req_write_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_read_data,
  output logic                   rsp_error
);
  dmem_state_t              state;
  logic [DMEM_CNT_BITS-1:0] cnt;
  logic [MEM_OP_BITS-1:0]   op_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     rsp_err_q;
  logic                     access;
  logic                     oob;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = |addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
  assign oob = 1'b0;
`endif
  assign access    = (state == DMEM_STATE_WAIT) && (cnt == '0);
  assign rsp_error = rsp_err_q;
  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (access && !oob),
    .we    (op_q == MEM_OP_WRITE),
    .clr   ((access && oob) || (state == DMEM_STATE_RESP && rsp_ready)),
    .addr  (addr_q[DEPTH_LOG2-1:0]),
    .wdata (wdata_q),
    .rdata (rsp_read_data)
  );
  // NOP requests are consumed in IDLE simply by never leaving it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= DMEM_STATE_IDLE;
      cnt       <= '0;
      op_q      <= MEM_OP_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        DMEM_STATE_IDLE:
          if (req_valid && req_ready && is_mem_access(req_mem_op)) begin
            op_q      <= req_mem_op;
            addr_q    <= req_address;
            wdata_q   <= req_write_data;
            cnt       <= DMEM_CNT_BITS'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= DMEM_STATE_WAIT;
          end
        DMEM_STATE_WAIT:
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_err_q <= oob;
            state     <= DMEM_STATE_RESP;
          end else cnt <= cnt - 1'b1;
        DMEM_STATE_RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err_q <= 1'b0;
            req_ready <= 1'b1;
            state     <= DMEM_STATE_IDLE;
          end
        default: state <= DMEM_STATE_IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed self-checking bench for data_memory_responder at LATENCY=2.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mem_op = MEM_OP_NOP;
  logic [15:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_read_data;
  logic        rsp_error;
  int checks = 0;
  int failures = 0;
  data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mem_op     (req_mem_op),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_read_data  (rsp_read_data),
    .rsp_error      (rsp_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_mem_op = op;
    req_address = addr;
    req_write_data = data;
  endtask
  // Full transaction from an idle negedge; hold = cycles rsp_ready stays low once rsp_valid is up
  task automatic txn(input string tag, input logic [1:0] op, input logic [15:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err,
                     input int hold);
    @(negedge clk);
    check({tag, ".idle_ready"}, req_ready, 1);
    drive(op, addr, data);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".busy_ready"}, req_ready, 0);
    check({tag, ".early_valid0"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, ".early_valid1"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rsp_data"}, rsp_read_data, exp_data);
    check({tag, ".rsp_error"}, rsp_error, exp_err);
    check({tag, ".resp_ready"}, req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, rsp_valid, 1);
      check({tag, ".hold_data"}, rsp_read_data, exp_data);
      check({tag, ".hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".done_valid"}, rsp_valid, 0);
    check({tag, ".done_data"}, rsp_read_data, 0);
    check({tag, ".done_error"}, rsp_error, 0);
    check({tag, ".done_ready"}, req_ready, 1);
  endtask
  initial begin
    // reset behaviour
    @(negedge clk);
    check("rst.req_ready", req_ready, 1);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_data", rsp_read_data, 0);
    check("rst.rsp_error", rsp_error, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel.req_ready", req_ready, 1);
    check("rel.rsp_valid", rsp_valid, 0);
    check("rel.rsp_data", rsp_read_data, 0);
    // write then read back
    txn("wr10", MEM_OP_WRITE, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn("rd10", MEM_OP_READ, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    // back-pressure on the response
    txn("rd10_hold", MEM_OP_READ, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    // NOP is consumed without a response and does not touch storage
    @(negedge clk);
    drive(MEM_OP_NOP, 16'h0010, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("nop.ready", req_ready, 1);
    check("nop.valid0", rsp_valid, 0);
    @(negedge clk);
    check("nop.valid1", rsp_valid, 0);
    @(negedge clk);
    check("nop.valid2", rsp_valid, 0);
    txn("rd10_nop", MEM_OP_READ, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    // second request held during WAIT is only accepted after the first response
    @(negedge clk);
    drive(MEM_OP_WRITE, 16'h0030, 32'hCAFEF00D);
    @(negedge clk);
    drive(MEM_OP_WRITE, 16'h0011, 32'h12345678);
    check("ovl.busy", req_ready, 0);
    @(negedge clk);
    check("ovl.wait_valid", rsp_valid, 0);
    @(negedge clk);
    check("ovl.rsp_valid", rsp_valid, 1);
    check("ovl.rsp_data", rsp_read_data, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ovl.idle_ready", req_ready, 1);
    check("ovl.idle_valid", rsp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("ovl2.accepted", req_ready, 0);
    @(negedge clk);
    check("ovl2.wait_valid", rsp_valid, 0);
    @(negedge clk);
    check("ovl2.rsp_valid", rsp_valid, 1);
    check("ovl2.rsp_data", rsp_read_data, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ovl2.done_ready", req_ready, 1);
    txn("rd30", MEM_OP_READ, 16'h0030, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    txn("rd11", MEM_OP_READ, 16'h0011, 32'h0, 32'h12345678, 1'b0, 0);
    // reset during WAIT aborts the write
    txn("wr20", MEM_OP_WRITE, 16'h0020, 32'h5555AAAA, 32'h0, 1'b0, 0);
    @(negedge clk);
    drive(MEM_OP_WRITE, 16'h0020, 32'h99999999);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.accepted", req_ready, 0);
    reset = 1'b0;
    #1;
    check("abort.async_ready", req_ready, 1);
    check("abort.async_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort.no_rsp", rsp_valid, 0);
    end
    txn("rd20", MEM_OP_READ, 16'h0020, 32'h0, 32'h5555AAAA, 1'b0, 0);
    // out-of-range address
    txn("wr00", MEM_OP_WRITE, 16'h0000, 32'h00000777, 32'h0, 1'b0, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    txn("wr400", MEM_OP_WRITE, 16'h0400, 32'h0BADF00D, 32'h0, 1'b1, 0);
    txn("rd400", MEM_OP_READ, 16'h0400, 32'h0, 32'h0, 1'b1, 0);
    txn("rd00", MEM_OP_READ, 16'h0000, 32'h0, 32'h00000777, 1'b0, 0);
`else
    txn("wr400", MEM_OP_WRITE, 16'h0400, 32'h0BADF00D, 32'h0, 1'b0, 0);
    txn("rd400", MEM_OP_READ, 16'h0400, 32'h0, 32'h0BADF00D, 1'b0, 0);
    txn("rd00", MEM_OP_READ, 16'h0000, 32'h0, 32'h0BADF00D, 1'b0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
